pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage RV32I core. It drives the stall, interlock and flush inputs of the pipeline registers, including the ID/EX register. It detects load-use hazards, freezes the pipeline while data memory is not ready, and squashes IF/ID and ID/EX on branch/jump redirects. It also enforces a data-memory timeout that raises a bus-error trap.

Parameters:
DMEM_TIMEOUT, 15, max DWAIT cycles before the access is abandoned (legal range 1..255)
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > DMEM_TIMEOUT

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
id_rs1  input  5  rs1 of the instruction in ID
id_rs2  input  5  rs2 of the instruction in ID
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
ex_rd  input  5  rd of the instruction in EX
ex_is_load  input  1  EX instruction is a load
ex_wr_reg_n  input  1  EX register write enable, active-low
redirect  input  1  EX resolved a taken branch or jump
dmem_req  input  1  MEM stage issuing a data access this cycle
dmem_ready  input  1  data memory completes the access this cycle
stall  output  1  freeze all pipeline registers and the PC
interlock  output  1  insert a bubble into ID/EX; hold PC and IF/ID
flush  output  1  kill the IF/ID and ID/EX contents
bus_err  output  1  one-cycle pulse: data access timed out
trap_sel  output  1  PC mux selects the trap vector (mirrors bus_err)
state_out  output  2  current FSM state, for debug: 0 RUN, 1 DWAIT, 2 DERR

Behaviour:
- Reset (async): state=RUN, cnt=0. All outputs are 0 while rst_n=0; interlock and flush are gated off during reset.
- States: RUN, DWAIT, DERR. All outputs are combinational from state and inputs (zero-cycle latency); state and cnt are registered.
- Raw hazard signals:
  - load_use = ex_is_load & ~ex_wr_reg_n & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))
  - mem_wait = dmem_req & ~dmem_ready
- RUN, in priority order:
  - mem_wait: stall=1, flush=0, interlock=0; next state DWAIT, cnt<=0.
  - Else redirect: flush=1, interlock=0 (the ID instruction is squashed anyway); stay in RUN.
  - Else load_use: interlock=1; stay in RUN.
  - Else all outputs 0.
- DWAIT:
  - stall = ~dmem_ready; flush=0, interlock=0.
  - dmem_ready=1: stall=0 this cycle, next state RUN.
  - Else cnt==DMEM_TIMEOUT-1: next state DERR.
  - Else cnt<=cnt+1.
  - Maximum stall length = 1 (RUN entry cycle) + DMEM_TIMEOUT cycles.
- DERR (exactly one cycle):
  - stall=0, flush=1, bus_err=1, trap_sel=1, interlock=0.
  - Next state RUN.
- Redirect during a memory stall: stall wins and flush stays 0. The frozen EX register keeps redirect asserted, so the flush is issued in the first RUN cycle after release.
- Load-use during a memory stall: interlock stays 0 while stall=1 and is re-evaluated after release.
- dmem_req deasserted while in DWAIT is a protocol violation; the FSM still waits for dmem_ready or the timeout.
- cnt never wraps; it saturates at DMEM_TIMEOUT-1 by construction.
- Reset asserted in DWAIT or DERR: immediate return to RUN, cnt=0, no bus_err pulse.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined: adds 32-bit output ports perf_stall_cyc, perf_ilock_cyc, perf_flush_cnt and perf_err_cnt.
  - Each counts the cycles in which stall, interlock, flush or bus_err respectively is 1.
  - Async reset to 0; counters wrap modulo 2^32.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
1. Load-use: ex_is_load=1, ex_wr_reg_n=0, ex_rd=5, id_rs1=5, id_use_rs1=1 -> interlock=1, stall=0. Repeat with ex_rd=0 -> interlock=0. Repeat with id_use_rs1=0 -> interlock=0.
2. Memory wait: dmem_req=1, dmem_ready low for 3 cycles then high -> stall=1 for 3 cycles, 0 on the ready cycle; state_out 0,1,1,1 then back to 0.
3. Timeout (DMEM_TIMEOUT=4): dmem_ready never asserted -> stall=1 for 5 cycles; next cycle bus_err=1, trap_sel=1, flush=1, state_out=2; then state_out=0.
4. redirect=1 and load_use=1 in the same RUN cycle -> flush=1, interlock=0.
5. redirect=1 held during a 2-cycle memory wait -> flush=0 while stall=1; flush=1 in the first cycle after dmem_ready.
6. Reset pulse at DWAIT cnt=2 -> all outputs 0, state_out=0, no bus_err pulse afterwards. With HAZARD_PERF_EN, also check counter values after scenario 3: perf_stall_cyc=5, perf_err_cnt=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central hazard/stall controller for the 5-stage RV32I pipeline.
//   - load-use detection -> interlock (bubble into ID/EX, hold PC and IF/ID)
//   - data-memory wait   -> stall (freeze everything)
//   - branch/jump        -> flush (squash IF/ID and ID/EX)
//   - data-memory timeout -> one-cycle bus_err / trap_sel pulse with flush
// Optional build macro: HAZARD_PERF_EN adds four 32-bit event counters.
//
// Data-memory handshake: the MEM stage holds dmem_req high for the whole
// access; the access completes in the cycle where dmem_req and dmem_ready
// are both high. A request with dmem_ready low freezes the pipeline until
// ready arrives or DMEM_TIMEOUT wait cycles have elapsed, at which point the
// access is abandoned and the bus-error trap is taken.
//
// All outputs are combinational from the registered state and the current
// inputs; only the FSM state, the timeout counter and the optional perf
// counters are flops. Every output is forced low while rst_n is low.

module pipeline_hazard_ctrl #(
    parameter int DMEM_TIMEOUT = 15,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_wr_reg_n,
    input  logic        redirect,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        stall,
    output logic        interlock,
    output logic        flush,
    output logic        bus_err,
    output logic        trap_sel,
`ifdef HAZARD_PERF_EN
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_ilock_cyc,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_err_cnt,
`endif
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_DERR  = 2'd2
    } state_t;

    // Last legal counter value: reaching it with no ready means timeout.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DMEM_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               load_use;
    logic               mem_wait;
    logic               rs1_hit;
    logic               rs2_hit;

    logic               stall_c;
    logic               interlock_c;
    logic               flush_c;
    logic               bus_err_c;

    // Raw hazard terms; a load to x0 or a load that does not write is harmless.
    always_comb begin
        rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
        load_use = ex_is_load && !ex_wr_reg_n && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
        mem_wait = dmem_req && !dmem_ready;
    end

    // Next-state, counter and output decode for the three-state controller.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_c     = 1'b0;
        interlock_c = 1'b0;
        flush_c     = 1'b0;
        bus_err_c   = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                // Memory stall beats redirect: the frozen EX keeps redirect
                // asserted, so the flush is issued after release.
                if (mem_wait) begin
                    stall_c = 1'b1;
                    state_d = ST_DWAIT;
                    cnt_d   = '0;
                end else if (redirect) begin
                    // ID instruction is squashed, no bubble needed.
                    flush_c = 1'b1;
                end else if (load_use) begin
                    interlock_c = 1'b1;
                end
            end

            ST_DWAIT: begin
                // dmem_req dropping here is a protocol violation; keep waiting
                // for ready or the timeout regardless.
                stall_c = !dmem_ready;
                if (dmem_ready) begin
                    state_d = ST_RUN;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DERR: begin
                // Abandoned access: kill the young instructions and take the trap.
                flush_c   = 1'b1;
                bus_err_c = 1'b1;
                state_d   = ST_RUN;
            end

            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and timeout counter; async reset returns straight to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs gated by reset so nothing leaks while rst_n is low.
    always_comb begin
        stall     = rst_n && stall_c;
        interlock = rst_n && interlock_c;
        flush     = rst_n && flush_c;
        bus_err   = rst_n && bus_err_c;
        trap_sel  = rst_n && bus_err_c;
        state_out = rst_n ? state_q : ST_RUN;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_ilock_q, perf_ilock_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_err_q,   perf_err_d;

    // Event counters: one increment per cycle the matching output is high.
    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, stall};
        perf_ilock_d = perf_ilock_q + {31'd0, interlock};
        perf_flush_d = perf_flush_q + {31'd0, flush};
        perf_err_d   = perf_err_q   + {31'd0, bus_err};
    end

    // Counter registers, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_ilock_q <= '0;
            perf_flush_q <= '0;
            perf_err_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_ilock_q <= perf_ilock_d;
            perf_flush_q <= perf_flush_d;
            perf_err_q   <= perf_err_d;
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_ilock_cyc = perf_ilock_q;
    assign perf_flush_cnt = perf_flush_q;
    assign perf_err_cnt   = perf_err_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl (DMEM_TIMEOUT = 4).
// Reference model tracks "stall cycles spent on the current access" and a
// pending-trap flag, and derives expected outputs directly from the rules.
module tb_pipeline_hazard_ctrl;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_is_load, ex_wr_reg_n;
  logic redirect, dmem_req, dmem_ready;
  logic stall, interlock, flush, bus_err, trap_sel;
  logic [1:0] state_out;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cyc, perf_ilock_cyc, perf_flush_cnt, perf_err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // model state
  int wait_len = 0;
  bit err_pend = 0;
  int m_stall_cnt = 0, m_ilock_cnt = 0, m_flush_cnt = 0, m_err_cnt = 0;

  // clock / reset block
  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DMEM_TIMEOUT(T), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_wr_reg_n(ex_wr_reg_n),
    .redirect(redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall(stall), .interlock(interlock), .flush(flush),
    .bus_err(bus_err), .trap_sel(trap_sel),
`ifdef HAZARD_PERF_EN
    .perf_stall_cyc(perf_stall_cyc), .perf_ilock_cyc(perf_ilock_cyc),
    .perf_flush_cnt(perf_flush_cnt), .perf_err_cnt(perf_err_cnt),
`endif
    .state_out(state_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_wr_reg_n = 1'b1;
    redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [4:0] rs1, input logic use1);
    ex_is_load = 1'b1; ex_wr_reg_n = 1'b0; ex_rd = rd;
    id_rs1 = rs1; id_use_rs1 = use1;
  endtask

  // Sample at negedge, compare against model, advance model, move past posedge.
  task automatic step(input string tag);
    logic lu;
    logic e_stall, e_il, e_fl, e_be;
    logic [1:0] e_st;
    @(negedge clk);
    lu = ex_is_load && !ex_wr_reg_n && (ex_rd != 5'd0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    e_stall = 0; e_il = 0; e_fl = 0; e_be = 0; e_st = 2'd0;
    if (!rst_n) begin
      wait_len = 0; err_pend = 0;
      m_stall_cnt = 0; m_ilock_cnt = 0; m_flush_cnt = 0; m_err_cnt = 0;
    end else if (err_pend) begin
      e_fl = 1; e_be = 1; e_st = 2'd2; err_pend = 0;
    end else if (wait_len > 0) begin
      e_st = 2'd1;
      e_stall = !dmem_ready;
      if (dmem_ready) wait_len = 0;
      else if (wait_len == T) begin err_pend = 1; wait_len = 0; end
      else wait_len++;
    end else if (dmem_req && !dmem_ready) begin
      e_stall = 1; wait_len = 1;
    end else if (redirect) begin
      e_fl = 1;
    end else if (lu) begin
      e_il = 1;
    end
    m_stall_cnt += int'(e_stall); m_ilock_cnt += int'(e_il);
    m_flush_cnt += int'(e_fl);    m_err_cnt   += int'(e_be);
    chk({tag, "_stall"},     32'(stall),     32'(e_stall));
    chk({tag, "_interlock"}, 32'(interlock), 32'(e_il));
    chk({tag, "_flush"},     32'(flush),     32'(e_fl));
    chk({tag, "_bus_err"},   32'(bus_err),   32'(e_be));
    chk({tag, "_trap_sel"},  32'(trap_sel),  32'(e_be));
    chk({tag, "_state"},     32'(state_out), 32'(e_st));
    @(posedge clk);
    #1;
  endtask

`ifdef HAZARD_PERF_EN
  task automatic chk_perf(input string tag);
    chk({tag, "_perf_stall"}, perf_stall_cyc, 32'(m_stall_cnt));
    chk({tag, "_perf_ilock"}, perf_ilock_cyc, 32'(m_ilock_cnt));
    chk({tag, "_perf_flush"}, perf_flush_cnt, 32'(m_flush_cnt));
    chk({tag, "_perf_err"},   perf_err_cnt,   32'(m_err_cnt));
  endtask
`endif

  initial begin
    int thresh;
    drive_idle();
    rst_n = 1'b0;
    // Outputs must stay low in reset even with every hazard present.
    dmem_req = 1'b1; redirect = 1'b1; drive_load(5'd5, 5'd5, 1'b1);
    #1;
    step("reset");
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step("idle");

    // 1. load-use
    drive_load(5'd5, 5'd5, 1'b1);              step("lu_hit");
    drive_load(5'd0, 5'd0, 1'b1);              step("lu_x0");
    drive_load(5'd5, 5'd5, 1'b0);              step("lu_nouse");
    drive_load(5'd7, 5'd1, 1'b0);
    id_rs2 = 5'd7; id_use_rs2 = 1'b1;          step("lu_rs2");
    ex_wr_reg_n = 1'b1;                        step("lu_nowr");
    drive_idle();

    // 2. memory wait, ready on 4th cycle
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) step("mwait");
    dmem_ready = 1'b1;                         step("mwait_rdy");
    drive_idle();                              step("mwait_after");

    // 3. timeout: 5 stall cycles, DERR, then RUN
    rst_n = 1'b0; step("pre_to_rst"); rst_n = 1'b1; @(posedge clk); #1;
    dmem_req = 1'b1;
    for (int i = 0; i < 5; i++) step("to_stall");
    step("to_derr");
    drive_idle();                              step("to_after");
`ifdef HAZARD_PERF_EN
    chk_perf("to");
`endif

    // 4. redirect beats load-use
    redirect = 1'b1; drive_load(5'd9, 5'd9, 1'b1); step("redir_lu");
    drive_idle();

    // 5. redirect held through a 2-cycle memory wait
    redirect = 1'b1; dmem_req = 1'b1;
    step("rw_entry");
    step("rw_wait");
    dmem_ready = 1'b1;                         step("rw_rdy");
    dmem_req = 1'b0; dmem_ready = 1'b0;        step("rw_flush");
    drive_idle();                              step("rw_idle");

    // 6. reset at DWAIT cnt=2
    dmem_req = 1'b1;
    step("rst_entry"); step("rst_c0"); step("rst_c1");
    rst_n = 1'b0; #1;
    step("rst_mid");
    rst_n = 1'b1; drive_idle();
    for (int i = 0; i < 6; i++) step("rst_after");

    // randomized stimulus
    thresh = 5;
    for (int n = 0; n < 800; n++) begin
      if (n % 40 == 0) thresh = $urandom_range(0, 9);
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom_range(0, 1));
      id_use_rs2 = 1'($urandom_range(0, 1));
      ex_is_load = 1'($urandom_range(0, 1));
      ex_wr_reg_n = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 4) == 0);
      dmem_req = ($urandom_range(0, 2) == 0);
      dmem_ready = ($urandom_range(0, 9) < thresh);
      rst_n = ($urandom_range(0, 149) != 0);
      #1;
      step("rand");
      rst_n = 1'b1;
    end
`ifdef HAZARD_PERF_EN
    chk_perf("end");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
